sm_c2_conv_pipe: RTL and testbench
==================================

Name: sm_c2_conv_pipe

Overview:
- Parametrised, pipelined, bidirectional converter between sign-magnitude (SM) and two's-complement (C2) for CHANNELS independent lanes of WIDTH bits.
- Sits between operand capture and the arithmetic datapath, and on the result path back to SM.
- valid/ready handshake on both sides; per-lane negative-zero and overflow flags; saturating overflow event counter.

Parameters:
- WIDTH, 8, bits per lane including sign bit (>=2)
- CHANNELS, 2, number of independent lanes converted per transfer (>=1)
- CNT_W, 16, width of saturating overflow counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept input beat
- mode  input  1  0 = SM->C2, 1 = C2->SM; sampled with input beat
- in_data  input  CHANNELS*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts output beat
- out_data  output  CHANNELS*WIDTH  converted lanes, same packing
- out_negzero  output  CHANNELS  per lane: SM input was negative zero (mode 0 only)
- out_ovf  output  CHANNELS  per lane: C2 input not representable in SM (mode 1 only)
- clr_cnt  input  1  synchronous clear of ovf_cnt
- ovf_cnt  output  CNT_W  saturating count of overflowed lanes delivered

Behaviour:
- Reset (async, rst=1): both stage valids 0, out_valid=0, out_data=0, out_negzero=0, out_ovf=0, ovf_cnt=0. in_ready=1 once stage 1 is empty, i.e. immediately after reset.
- Stage 1 register:
  - Captures in_data and mode on in_valid && in_ready.
  - in_ready = !s1_valid || s2_take.
  - s2_take = s1_valid && (!out_valid || out_ready).
- Stage 2 computes from stage-1 contents and registers out_data, flags and out_valid on s2_take.
  - out_valid clears on out_valid && out_ready without a new s2_take.
  - Latency: 2 cycles from input handshake to out_valid with no backpressure.
  - Throughput: 1 beat/cycle sustained.
- Backpressure:
  - While out_valid && !out_ready, out_data and all flags are held stable.
  - Stage 1 holds its beat; in_ready drops once stage 1 is full.
  - No beat is dropped or duplicated.
- Mode 0, SM->C2, per lane, with s = x[WIDTH-1] and m = x[WIDTH-2:0]:
  - s=0: out = x.
  - s=1: out = two's-complement negation of zero-extended m, i.e. 0 - {1'b0,m} mod 2^WIDTH.
  - s=1, m=0 (negative zero): out = 0, negzero=1.
  - ovf is always 0.
- Mode 1, C2->SM, per lane:
  - msb=0: out = x.
  - msb=1 and x != 100..0: out = {1'b1, (0 - x)[WIDTH-2:0]}.
  - x = 100..0 (most-negative value): saturate to out = all ones (= -(2^(WIDTH-1)-1) in SM), ovf=1.
  - negzero is always 0.
- Mode is per beat. Consecutive beats may alternate modes with no bubble.
- ovf_cnt:
  - On each output handshake (out_valid && out_ready), add popcount(out_ovf).
  - Saturate at 2^CNT_W-1; never wraps.
  - clr_cnt=1 sets ovf_cnt to 0 on that edge and takes priority over a simultaneous increment.
- Reset mid-operation discards all in-flight beats. No output handshake occurs in the reset cycle.

Test Plan (WIDTH=8, CHANNELS=2; lane0 listed first):
- Mode 0, in lanes 0x81, 0x05, out_ready=1 -> 2 cycles later out 0xFF, 0x05; negzero=00, ovf=00.
- Mode 0, in lanes 0x80, 0xFF -> out 0x00, 0x81; negzero=01 (lane0 set), ovf=00.
- Mode 1, in lanes 0xFF, 0x80 -> out 0x81, 0xFF; ovf=10 (lane1 set); ovf_cnt reads 1 after the handshake.
- Stream 4 beats (alternating modes, values 0x81, 0x7F, 0xC0, 0x00 on lane0) with out_ready low for cycles 2-5:
  - in_ready drops after 2 beats are held.
  - Outputs are stable while stalled.
  - All 4 beats emerge in order with correct values (0xFF, 0x7F, 0xC0 in mode 0 -> 0xC0, 0x00).
- Preload ovf_cnt to 0xFFFF via repeated 0x80/0x80 mode-1 beats (or a forced counter), then send one more such beat -> ovf_cnt stays 0xFFFF.
- Assert clr_cnt in the same cycle as an ovf handshake -> ovf_cnt=0.
- Assert rst with both stages full -> out_valid=0, ovf_cnt=0 immediately (asynchronous).
- After release, in_ready=1 and the next beat emerges with 2-cycle latency.

Source files
------------

// File: rtl/sm_c2_conv_if.sv
// Bus bundle for the sign-magnitude / two's-complement converter.
// The slave modport is the converter's view; the master modport is the producer/consumer view.
interface sm_c2_conv_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      mode;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_negzero;
  logic [CHANNELS-1:0]       out_ovf;
  logic                      clr_cnt;
  logic [CNT_W-1:0]          ovf_cnt;

  modport slave (
    input  in_valid, mode, in_data, out_ready, clr_cnt,
    output in_ready, out_valid, out_data, out_negzero, out_ovf, ovf_cnt
  );

  modport master (
    output in_valid, mode, in_data, out_ready, clr_cnt,
    input  in_ready, out_valid, out_data, out_negzero, out_ovf, ovf_cnt
  );
endinterface

// File: rtl/sm_c2_conv_pipe.sv
// Two-stage pipelined SM <-> C2 converter for CHANNELS lanes with valid/ready on both sides,
// per-lane negative-zero / overflow flags and a saturating overflow event counter.
module sm_c2_conv_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  sm_c2_conv_if.slave     bus
);

  localparam int unsigned DW     = WIDTH * CHANNELS;
  localparam int unsigned PCNT_W = $clog2(CHANNELS + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic                r_s1_valid;
  logic [DW-1:0]       r_s1_data;
  logic                r_s1_mode;
  logic                r_out_valid;
  logic [DW-1:0]       r_out_data;
  logic [CHANNELS-1:0] r_out_negzero;
  logic [CHANNELS-1:0] r_out_ovf;
  logic [CNT_W-1:0]    r_ovf_cnt;

  logic                w_s2_take;
  logic                w_in_fire;
  logic                w_out_fire;
  logic [DW-1:0]       w_data;
  logic [CHANNELS-1:0] w_negzero;
  logic [CHANNELS-1:0] w_ovf;
  logic [PCNT_W-1:0]   w_pop;
  logic [CNT_W:0]      w_cnt_sum;

  assign w_s2_take  = r_s1_valid && (!r_out_valid || bus.out_ready);
  assign bus.in_ready = !r_s1_valid || w_s2_take;
  assign w_in_fire  = bus.in_valid && bus.in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_negzero = r_out_negzero;
  assign bus.out_ovf     = r_out_ovf;
  assign bus.ovf_cnt     = r_ovf_cnt;

  // Per-lane conversion; the pattern 100..0 is both SM negative zero and the C2 most-negative value.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_neg_m;
    logic [WIDTH-1:0] w_neg_x;
    logic [WIDTH-1:0] w_c2_res;
    logic [WIDTH-1:0] w_sm_res;

    assign w_x      = r_s1_data[k*WIDTH +: WIDTH];
    assign w_neg_m  = WIDTH'(0) - {1'b0, w_x[WIDTH-2:0]};
    assign w_neg_x  = WIDTH'(0) - w_x;
    assign w_c2_res = w_x[WIDTH-1] ? w_neg_m : w_x;
    assign w_sm_res = !w_x[WIDTH-1]     ? w_x :
                      (w_x == MOST_NEG) ? {WIDTH{1'b1}} :
                                          {1'b1, w_neg_x[WIDTH-2:0]};

    assign w_data[k*WIDTH +: WIDTH] = r_s1_mode ? w_sm_res : w_c2_res;
    assign w_negzero[k] = !r_s1_mode && (w_x == MOST_NEG);
    assign w_ovf[k]     =  r_s1_mode && (w_x == MOST_NEG);
  end

  // Number of overflowed lanes in the beat currently presented downstream.
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_pop = w_pop + PCNT_W'(r_out_ovf[k]);
    end
  end

  assign w_cnt_sum = {1'b0, r_ovf_cnt} + (CNT_W+1)'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_data     <= '0;
      r_s1_mode     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_negzero <= '0;
      r_out_ovf     <= '0;
      r_ovf_cnt     <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= bus.in_data;
        r_s1_mode  <= bus.mode;
      end else if (w_s2_take) begin
        r_s1_valid <= 1'b0;
      end

      // Output register only loads on a stage-2 take, so it stays frozen under backpressure.
      if (w_s2_take) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_data;
        r_out_negzero <= w_negzero;
        r_out_ovf     <= w_ovf;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end

      if (bus.clr_cnt) begin
        r_ovf_cnt <= '0;
      end else if (w_out_fire) begin
        r_ovf_cnt <= w_cnt_sum[CNT_W] ? CNT_MAX : w_cnt_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_sm_c2_conv_pipe.sv
// Scoreboard bench for sm_c2_conv_pipe (WIDTH=8, CHANNELS=2): directed vectors, backpressure,
// random traffic, counter saturation / clear and asynchronous reset.
module tb_sm_c2_conv_pipe;

  localparam int unsigned W   = 8;
  localparam int unsigned CH  = 2;
  localparam int unsigned CW  = 16;
  localparam int          CNT_MAX = 65535;

  typedef struct {
    logic        mode;
    logic [15:0] data;
    logic [15:0] exp;
    logic [1:0]  nz;
    logic [1:0]  ovf;
    bit          lat;
    int          cyc;
  } beat_t;

  logic clk;
  logic rst;

  sm_c2_conv_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) bus ();

  sm_c2_conv_pipe #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t pend[$];
  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    model_cnt = 0;
  int    clr_hits  = 0;
  bit    tb_ready  = 1'b1;
  bit    rnd_mode  = 1'b0;
  bit    clr_arm   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference conversion using plain integer arithmetic.
  function automatic beat_t model(input bit m, input logic [15:0] d, input bit lat);
    beat_t b;
    b.mode = m; b.data = d; b.exp = '0; b.nz = '0; b.ovf = '0; b.lat = lat; b.cyc = 0;
    for (int k = 0; k < 2; k++) begin
      int x;
      int o;
      x = int'(d[k*8 +: 8]);
      if (x < 128) o = x;
      else if (!m) begin
        o = (256 - (x - 128)) % 256;
        if (x == 128) b.nz[k] = 1'b1;
      end else if (x == 128) begin
        o = 255;
        b.ovf[k] = 1'b1;
      end else o = 128 + (256 - x);
      b.exp[k*8 +: 8] = 8'(o);
    end
    return b;
  endfunction

  task automatic push_dir(input bit m, input logic [15:0] d, input logic [15:0] e,
                          input logic [1:0] nz, input logic [1:0] ovf, input bit lat);
    beat_t b;
    b.mode = m; b.data = d; b.exp = e; b.nz = nz; b.ovf = ovf; b.lat = lat; b.cyc = 0;
    pend.push_back(b);
  endtask

  // One clock: drive in the low phase, evaluate handshakes, then let the edge happen.
  task automatic cycle();
    bit in_fire;
    bit out_fire;
    beat_t e;
    @(negedge clk);
    if (rnd_mode) tb_ready = ($urandom_range(0, 2) != 0);
    bus.in_valid = (pend.size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
    if (pend.size() > 0) begin
      bus.mode    = pend[0].mode;
      bus.in_data = pend[0].data;
    end
    bus.out_ready = tb_ready;
    #1;
    bus.clr_cnt = clr_arm && bus.out_valid && bus.out_ready && (bus.out_ovf != 2'b00);
    check("ovf_cnt", 64'(bus.ovf_cnt), 64'(model_cnt));
    out_fire = bus.out_valid && bus.out_ready;
    in_fire  = bus.in_valid && bus.in_ready;
    if (out_fire) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", 64'(bus.out_data), 64'(e.exp));
        check("negzero", 64'(bus.out_negzero), 64'(e.nz));
        check("ovf", 64'(bus.out_ovf), 64'(e.ovf));
        if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
        model_cnt = model_cnt + int'(e.ovf[0]) + int'(e.ovf[1]);
        if (model_cnt > CNT_MAX) model_cnt = CNT_MAX;
      end
    end
    if (bus.clr_cnt) begin
      model_cnt = 0;
      clr_hits++;
    end
    if (in_fire) begin
      e = pend.pop_front();
      e.cyc = cyc;
      sb.push_back(e);
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (pend.size() == 0 && sb.size() == 0 && !bus.out_valid) break;
      cycle();
    end
    check("drain_left", 64'(pend.size() + sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.mode = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b1; bus.clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_flags", 64'({bus.out_negzero, bus.out_ovf}), 64'd0);
    check("rst_ovf_cnt", 64'(bus.ovf_cnt), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk); rst = 1'b0;

    // Directed conversions.
    push_dir(1'b0, 16'h0581, 16'h05FF, 2'b00, 2'b00, 1'b1);
    drain(20);
    push_dir(1'b0, 16'hFF80, 16'h8100, 2'b01, 2'b00, 1'b0);
    push_dir(1'b1, 16'h80FF, 16'hFF81, 2'b00, 2'b10, 1'b0);
    drain(20);
    check("cnt_after_ovf", 64'(bus.ovf_cnt), 64'd1);

    // Backpressure: four alternating-mode beats while the sink stalls.
    tb_ready = 1'b0;
    push_dir(1'b0, 16'h0081, 16'h00FF, 2'b00, 2'b00, 1'b0);
    push_dir(1'b1, 16'h007F, 16'h007F, 2'b00, 2'b00, 1'b0);
    push_dir(1'b0, 16'h00C0, 16'h00C0, 2'b00, 2'b00, 1'b0);
    push_dir(1'b1, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0);
    cycle(); cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_data", 64'(bus.out_data), 64'(sb[0].exp));
      cycle();
    end
    check("stall_pending", 64'(pend.size()), 64'd2);
    tb_ready = 1'b1;
    drain(40);

    // Random traffic with random source gaps and sink stalls.
    rnd_mode = 1'b1;
    for (int i = 0; i < 60; i++)
      pend.push_back(model(1'($urandom_range(0, 1)), 16'($urandom), 1'b0));
    for (int i = 0; i < 4; i++) pend.push_back(model(1'(i), 16'h8080, 1'b0));
    drain(1000);
    rnd_mode = 1'b0;
    tb_ready = 1'b1;

    // Saturate the counter, then one more overflowing beat.
    for (int i = 0; i < 32768; i++) pend.push_back(model(1'b1, 16'h8080, 1'b0));
    drain(40000);
    check("cnt_sat", 64'(bus.ovf_cnt), 64'hFFFF);
    pend.push_back(model(1'b1, 16'h8080, 1'b0));
    drain(20);
    check("cnt_sat_hold", 64'(bus.ovf_cnt), 64'hFFFF);

    // Clear coinciding with an overflow handshake.
    clr_arm = 1'b1;
    pend.push_back(model(1'b1, 16'h8080, 1'b0));
    drain(20);
    clr_arm = 1'b0;
    bus.clr_cnt = 1'b0;
    check("clr_hit", 64'(clr_hits), 64'd1);
    check("cnt_cleared", 64'(bus.ovf_cnt), 64'd0);

    // Asynchronous reset with both stages full.
    pend.push_back(model(1'b1, 16'h8080, 1'b0));
    drain(20);
    check("cnt_pre_rst", 64'(bus.ovf_cnt), 64'd2);
    tb_ready = 1'b0;
    for (int i = 0; i < 3; i++) pend.push_back(model(1'b1, 16'h8080, 1'b0));
    cycle(); cycle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_ovf_cnt", 64'(bus.ovf_cnt), 64'd0);
    check("arst_out_data", 64'(bus.out_data), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    pend.delete();
    sb.delete();
    model_cnt = 0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    push_dir(1'b0, 16'h8081, 16'h00FF, 2'b10, 2'b00, 1'b1);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
